// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : parametrised multi-port register file with a busy scoreboard
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   RegWrite        per-write-port enable          [NWR]
//   Write_ADDR      write addresses, port k at [k*ADSize +: ADSize]
//   DIN             write data,      port k at [k*DASize +: DASize]
//   Read_ADDR       read addresses,  lane j at [j*ADSize +: ADSize]
//   OUT             read data (combinational), lane j at [j*DASize +: DASize]
//   Busy_Set        mark Busy_ADDR as pending at the next edge
//   Busy_ADDR       register to mark pending
//   Busy            registered per-register pending flags
//   Write_Conflict  registered; high the cycle after two live ports hit the
//                   same address
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DASize  = 32,
    parameter int ADSize  = 5,
    parameter int REGSize = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWR-1:0]           RegWrite,
    input  logic [NWR*ADSize-1:0]    Write_ADDR,
    input  logic [NWR*DASize-1:0]    DIN,
    input  logic [NRD*ADSize-1:0]    Read_ADDR,
    output logic [NRD*DASize-1:0]    OUT,
    input  logic                     Busy_Set,
    input  logic [ADSize-1:0]        Busy_ADDR,
    output logic [REGSize-1:0]       Busy,
    output logic                     Write_Conflict
);

    logic [REGSize-1:0][DASize-1:0] r_mem;
    logic [REGSize-1:0]             r_busy;
    logic                           r_conflict;

    logic [NWR-1:0]                 w_wr_ok;     // port hits a writable register
    logic [REGSize-1:0]             w_wen;       // per-register write strobe
    logic [REGSize-1:0][DASize-1:0] w_wdata;     // winning data per register
    logic                           w_conflict;
    logic [REGSize-1:0]             w_busy_nxt;

    // Register 0 is read-only zero when ZERO_R0 is set.
    function automatic logic reg_ok(input int r);
        return !((ZERO_R0 != 0) && (r == 0));
    endfunction

    // Write decode is done per register by address compare rather than by
    // indexing, so out-of-range addresses simply match nothing. Ports are
    // scanned in ascending order, so the highest enabled port wins.
    always_comb begin
        w_wr_ok = '0;
        w_wen   = '0;
        w_wdata = '0;
        for (int r = 0; r < REGSize; r++) begin
            for (int k = 0; k < NWR; k++) begin
                if (RegWrite[k] && reg_ok(r) &&
                    Write_ADDR[k*ADSize +: ADSize] == ADSize'(r)) begin
                    w_wr_ok[k] = 1'b1;
                    w_wen[r]   = 1'b1;
                    w_wdata[r] = DIN[k*DASize +: DASize];
                end
            end
        end
    end

    // Only live (non-ignored) writes can collide.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int k = i + 1; k < NWR; k++) begin
                if (w_wr_ok[i] && w_wr_ok[k] &&
                    Write_ADDR[i*ADSize +: ADSize] == Write_ADDR[k*ADSize +: ADSize])
                    w_conflict = 1'b1;
            end
        end
    end

    // A write retires the pending producer; a same-cycle set is a new
    // producer and takes precedence.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < REGSize; r++) begin
            if (w_wen[r])
                w_busy_nxt[r] = 1'b0;
            if (Busy_Set && reg_ok(r) && Busy_ADDR == ADSize'(r))
                w_busy_nxt[r] = 1'b1;
        end
    end

    // Read lanes: array value, overridden by the incoming write data when
    // bypass is enabled. Unmatched or zero-register addresses read 0.
    always_comb begin
        OUT = '0;
        for (int j = 0; j < NRD; j++) begin
            for (int r = 0; r < REGSize; r++) begin
                if (Read_ADDR[j*ADSize +: ADSize] == ADSize'(r)) begin
                    if (reg_ok(r))
                        OUT[j*DASize +: DASize] = r_mem[r];
                    if ((BYPASS != 0) && w_wen[r])
                        OUT[j*DASize +: DASize] = w_wdata[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem      <= '0;
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            for (int r = 0; r < REGSize; r++) begin
                if (w_wen[r])
                    r_mem[r] <= w_wdata[r];
            end
            r_busy     <= w_busy_nxt;
            r_conflict <= w_conflict;
        end
    end

    assign Busy           = r_busy;
    assign Write_Conflict = r_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp : table-driven bench for regfile_mp. Three instances share
// the stimulus: default (bypass), BYPASS=0, and REGSize=16. Combinational
// read data is checked mid-cycle; registered Busy / Write_Conflict
// expectations are queued when a vector is driven and popped after the edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  RegWrite = '0;
    logic [9:0]  Write_ADDR = '0;
    logic [63:0] DIN = '0;
    logic [9:0]  Read_ADDR = '0;
    logic        Busy_Set = 1'b0;
    logic [4:0]  Busy_ADDR = '0;

    logic [63:0] out_m, out_nb, out_16;
    logic [31:0] busy_m, busy_nb;
    logic [15:0] busy_16;
    logic        wc_m, wc_nb, wc_16;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .Write_ADDR(Write_ADDR),
        .DIN(DIN), .Read_ADDR(Read_ADDR), .OUT(out_m), .Busy_Set(Busy_Set),
        .Busy_ADDR(Busy_ADDR), .Busy(busy_m), .Write_Conflict(wc_m));

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .Write_ADDR(Write_ADDR),
        .DIN(DIN), .Read_ADDR(Read_ADDR), .OUT(out_nb), .Busy_Set(Busy_Set),
        .Busy_ADDR(Busy_ADDR), .Busy(busy_nb), .Write_Conflict(wc_nb));

    regfile_mp #(.REGSize(16)) u_r16 (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .Write_ADDR(Write_ADDR),
        .DIN(DIN), .Read_ADDR(Read_ADDR), .OUT(out_16), .Busy_Set(Busy_Set),
        .Busy_ADDR(Busy_ADDR), .Busy(busy_16), .Write_Conflict(wc_16));

    typedef struct {
        bit          rst;
        bit          chk;        // check combinational reads this vector
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] d0, d1;
        logic [4:0]  ra0, ra1;
        bit          bset;
        logic [4:0]  baddr;
        logic [31:0] o0, o1;     // bypass instance, same cycle
        logic [31:0] n0, n1;     // no-bypass instance, same cycle
        logic [31:0] busy;       // after the edge
        bit          wc;         // after the edge
    } vec_t;

    typedef struct {
        logic [31:0] busy;
        bit          wc;
    } post_t;

    vec_t  vecs[$];
    post_t sb[$];
    int    n_pass = 0;
    int    n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(
        bit r, bit c, logic [1:0] we, logic [4:0] wa0, logic [31:0] d0,
        logic [4:0] wa1, logic [31:0] d1, logic [4:0] ra0, logic [4:0] ra1,
        bit bs, logic [4:0] ba, logic [31:0] o0, logic [31:0] o1,
        logic [31:0] n0, logic [31:0] n1, logic [31:0] busy, bit wc);
        vec_t v;
        v.rst = r; v.chk = c; v.we = we; v.wa0 = wa0; v.d0 = d0; v.wa1 = wa1;
        v.d1 = d1; v.ra0 = ra0; v.ra1 = ra1; v.bset = bs; v.baddr = ba;
        v.o0 = o0; v.o1 = o1; v.n0 = n0; v.n1 = n1; v.busy = busy; v.wc = wc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst        = v.rst;
        RegWrite   = v.we;
        Write_ADDR = {v.wa1, v.wa0};
        DIN        = {v.d1, v.d0};
        Read_ADDR  = {v.ra1, v.ra0};
        Busy_Set   = v.bset;
        Busy_ADDR  = v.baddr;
    endtask

    localparam logic [31:0] B7  = 32'h0000_0080;
    localparam logic [31:0] B31 = 32'h8000_0000;
    localparam logic [31:0] B20 = 32'h0010_0000;

    initial begin
        post_t p;
        // rst c  we     wa0 d0      wa1 d1     ra0 ra1 bs ba  o0     o1     n0     n1     busy wc
        vecs.push_back(mk(1, 0, 2'b00, 0, 0,     0, 0,     1, 2, 0, 0,  0,     0,     0,     0,     0,   0)); // reset
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     1, 2, 0, 0,  0,     0,     0,     0,     0,   0)); // readback 0
        vecs.push_back(mk(0, 1, 2'b11, 1, 'h2,   2, 'h3,   1, 2, 0, 0,  'h2,   'h3,   0,     0,     0,   0)); // dual write
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     1, 2, 0, 0,  'h2,   'h3,   'h2,   'h3,   0,   0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 'h1,   0, 0,     0, 1, 0, 0,  0,     'h2,   0,     'h2,   0,   0)); // write r0
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     0, 3, 0, 0,  0,     0,     0,     0,     0,   0));
        vecs.push_back(mk(0, 1, 2'b01, 3, 'h4,   0, 0,     3, 1, 0, 0,  'h4,   'h2,   0,     'h2,   0,   0)); // bypass
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     3, 5, 0, 0,  'h4,   0,     'h4,   0,     0,   0));
        vecs.push_back(mk(0, 1, 2'b11, 5, 'hA,   5, 'hB,   5, 3, 0, 0,  'hB,   'h4,   0,     'h4,   0,   1)); // conflict
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     5, 5, 0, 0,  'hB,   'hB,   'hB,   'hB,   0,   0));
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     7, 5, 1, 7,  0,     'hB,   0,     'hB,   B7,  0)); // busy set
        vecs.push_back(mk(0, 1, 2'b01, 7, 'h70,  0, 0,     7, 0, 0, 0,  'h70,  0,     0,     0,     0,   0)); // write clears
        vecs.push_back(mk(0, 1, 2'b10, 0, 0,     7, 'h71,  7, 1, 1, 7,  'h71,  'h2,   'h70,  'h2,   B7,  0)); // set wins
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     7, 2, 1, 0,  'h71,  'h3,   'h71,  'h3,   B7,  0)); // busy r0 ignored
        vecs.push_back(mk(0, 1, 2'b11, 0, 'h5,   0, 'h6,   0, 7, 0, 0,  0,     'h71,  0,     'h71,  B7,  0)); // ignored conflict
        vecs.push_back(mk(1, 0, 2'b01, 4, 'hF,   0, 0,     4, 7, 1, 4,  0,     0,     0,     0,     0,   0)); // reset mid-op
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     4, 7, 0, 0,  0,     0,     0,     0,     0,   0));
        vecs.push_back(mk(0, 1, 2'b00, 0, 0,     0, 0,     1, 2, 1, 31, 0,     0,     0,     0,     B31, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            if (vecs[i].chk) begin
                chk($sformatf("v%0d out0", i),    out_m[31:0],   vecs[i].o0);
                chk($sformatf("v%0d out1", i),    out_m[63:32],  vecs[i].o1);
                chk($sformatf("v%0d nb_out0", i), out_nb[31:0],  vecs[i].n0);
                chk($sformatf("v%0d nb_out1", i), out_nb[63:32], vecs[i].n1);
            end
            p.busy = vecs[i].busy;
            p.wc   = vecs[i].wc;
            sb.push_back(p);
            @(posedge clk);
            #1;
            p = sb.pop_front();
            chk($sformatf("v%0d busy", i),    busy_m,  p.busy);
            chk($sformatf("v%0d wc", i),      {31'b0, wc_m},  {31'b0, p.wc});
            chk($sformatf("v%0d nb_busy", i), busy_nb, p.busy);
            chk($sformatf("v%0d nb_wc", i),   {31'b0, wc_nb}, {31'b0, p.wc});
        end

        // Out-of-range on the 16-entry instance: addr 20 must not alias addr 4,
        // and a colliding pair of ignored writes must not flag a conflict.
        @(negedge clk);
        drive(mk(0, 1, 2'b11, 20, 'h77, 20, 'h88, 20, 4, 1, 20, 0, 0, 0, 0, 0, 0));
        #1;
        chk("oor main out0 bypass", out_m[31:0],   32'h88);
        chk("oor r16 out0",         out_16[31:0],  32'h0);
        chk("oor r16 out1",         out_16[63:32], 32'h0);
        @(posedge clk);
        #1;
        chk("oor main wc",   {31'b0, wc_m},  32'h1);
        chk("oor r16 wc",    {31'b0, wc_16}, 32'h0);
        chk("oor main busy", busy_m,  B31 | B20);
        chk("oor r16 busy",  {16'b0, busy_16}, 32'h0);

        @(negedge clk);
        drive(mk(0, 1, 2'b00, 0, 0, 0, 0, 20, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("oor main out0 stored", out_m[31:0],   32'h88);
        chk("oor r16 read 20",      out_16[31:0],  32'h0);
        chk("oor r16 no alias 4",   out_16[63:32], 32'h0);
        @(posedge clk);
        #1;
        chk("oor main wc clears", {31'b0, wc_m}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the single-write/dual-read RegFile in the CPU datapath.
- Adds configurable read/write port counts, optional hard-wired zero register and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard for pipeline hazard detection and a registered write-conflict flag.
- Sits between the decode stage (read ports, busy set) and the writeback stage (write ports).

Parameters:
- DASize, 32, data width in bits.
- ADSize, 5, address width in bits.
- REGSize, 32, number of registers; must be <= 2**ADSize.
- NRD, 2, number of read ports (1..4).
- NWR, 2, number of write ports (1..2).
- ZERO_R0, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a read of an address being written this cycle returns the incoming DIN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWrite  in  NWR  per-port write enable.
- Write_ADDR  in  NWR*ADSize  write addresses; port k at bits [k*ADSize +: ADSize].
- DIN  in  NWR*DASize  write data; port k at bits [k*DASize +: DASize].
- Read_ADDR  in  NRD*ADSize  read addresses, packed the same way.
- OUT  out  NRD*DASize  read data, combinational from array and bypass.
- Busy_Set  in  1  mark register Busy_ADDR as pending.
- Busy_ADDR  in  ADSize  register to mark pending.
- Busy  out  REGSize  per-register pending flags, registered.
- Write_Conflict  out  1  registered; high the cycle after two enabled ports wrote the same address.

Behaviour:
- Reset: clocked with rst=1 clears all registers to 0, Busy to 0 and Write_Conflict to 0.
  - rst dominates any simultaneous write or Busy_Set.
  - From the first cycle after the reset edge, every OUT lane reads 0.
- Write:
  - On the rising edge, each port k with RegWrite[k]=1 stores its DIN slice at its Write_ADDR.
  - Write latency: 1 cycle; visible through the array the cycle after the edge.
- Write priority: if two enabled ports target the same address, the higher port index wins.
  - Write_Conflict=1 for exactly the next cycle, then returns to 0 unless the conflict repeats.
- Ignored writes:
  - Any write with Write_ADDR >= REGSize.
  - Any write to address 0 when ZERO_R0=1.
  - Ignored writes do not change the array and do not raise Write_Conflict.
- Read (asynchronous):
  - OUT lane j = mem[Read_ADDR j].
  - Reads 0 if Read_ADDR j >= REGSize, or if ZERO_R0=1 and the address is 0.
- Bypass (BYPASS=1):
  - If an enabled, non-ignored write targets Read_ADDR j this cycle, OUT lane j = that DIN.
  - If both write ports match, the highest-index port's DIN is returned.
  - BYPASS=0: lane j returns the old value until the edge.
- Scoreboard:
  - Busy_Set=1 with a valid Busy_ADDR sets Busy[Busy_ADDR] at the edge.
  - Any non-ignored write clears Busy[Write_ADDR] at the edge.
  - Set and write to the same address in one cycle: set wins, bit stays 1 (new producer).
  - Busy_ADDR >= REGSize is ignored. Busy[0] is never set when ZERO_R0=1.
- Reset mid-operation: pending writes and busy sets in the reset cycle are discarded.
- No internal FSM beyond array, busy vector and conflict flop. All state is synchronous to clk.

Test Plan:
- Reset then readback: rst=1 for 1 cycle, Read_ADDR={1,2} -> OUT={0,0}, Busy=0, Write_Conflict=0.
- Dual write then read:
  - Stimulus: port0 writes addr 1 = 'h2 and port1 writes addr 2 = 'h3 in one cycle; next cycle read {1,2}.
  - Required: OUT={'h2,'h3}.
  - With ZERO_R0=1, a write of 'h1 to addr 0 then a read of addr 0 -> OUT=0.
- Bypass:
  - BYPASS=1: write addr 3 = 'h4 while reading addr 3 -> OUT='h4 in the same cycle.
  - BYPASS=0: same stimulus -> old value (0) that cycle, 'h4 the next cycle.
- Conflict:
  - Stimulus: both ports write addr 5, port0='hA, port1='hB.
  - Required: Write_Conflict=1 for one cycle, then mem[5]='hB.
  - A same-cycle read of addr 5 with BYPASS=1 -> 'hB.
- Scoreboard:
  - Busy_Set addr 7 -> Busy[7]=1 next cycle.
  - A write to 7 -> Busy[7]=0 next cycle.
  - Busy_Set addr 7 plus a write to 7 in the same cycle -> Busy[7] stays 1.
- Reset mid-operation and out-of-range:
  - Assert rst during a write of 'hF to addr 4 and a Busy_Set on addr 4 -> mem[4]=0, Busy[4]=0.
  - With REGSize=16, a write to addr 20 changes nothing, and a read of addr 20 -> 0.
